uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter (50 MHz, 115200 baud, 8 data bits, optional parity, 1 stop bit) among four requesters. It latches the winner's byte and the parity mode, issues a single-cycle start to the transmitter, and tracks the transmitter's busy handshake to completion. It then enforces an inter-frame gap before the next grant. It sits between application logic (command responders, status reporters) and the transmit datapath, mirroring the receive side of the UART.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, parity codes, baud timing.
package uart_pkg;

  localparam int unsigned BASE_FREQ      = 50_000_000;
  localparam int unsigned BAUDRATE       = 115_200;
  localparam int unsigned COUNTS_PER_BIT = BASE_FREQ / BAUDRATE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  // Code 3 is reserved and behaves as no parity.
  function automatic logic [1:0] norm_parity(input logic [1:0] p);
    return (p == 2'd3) ? 2'(PAR_NONE) : p;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the shared UART transmit arbiter.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [1:0]  cfg_parity_type;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  tx_parity_type;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        arb_busy;

  modport master (
    input  req, req_data, cfg_parity_type, tx_busy,
    output tx_start, tx_data, tx_parity_type, grant, done, err, arb_busy
  );

  modport slave (
    output req, req_data, cfg_parity_type, tx_busy,
    input  tx_start, tx_data, tx_parity_type, grant, done, err, arb_busy
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set req bit at or above rr_ptr, wrapping 3 to 0.
module uart_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic [3:0] win,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// Define UART_ARB_WDOG_EN to abort frames whose tx_busy never rises.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GAP_CYCLES  = COUNTS_PER_BIT,
  parameter int unsigned WDOG_CYCLES = 2 * COUNTS_PER_BIT
) (
  input logic              clk,
  input logic              one_shot_rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned CTR_MAX = (GAP_CYCLES > WDOG_CYCLES) ? GAP_CYCLES : WDOG_CYCLES;
  localparam int unsigned CTR_W   = $clog2(CTR_MAX);

  arb_state_t       state;
  logic [1:0]       rr_ptr;
  logic [1:0]       owner;
  logic [CTR_W-1:0] gap_ctr;
  logic [3:0]       pick_win;
  logic             pick_valid;
  logic [1:0]       pick_idx;

  uart_rr_pick u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .win    (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (pick_win[i]) pick_idx = 2'(i);
  end

`ifdef UART_ARB_WDOG_EN
  logic [CTR_W-1:0] wdog_ctr;
`else
  assign bus.err = '0;
`endif

  always_ff @(posedge clk or posedge one_shot_rst) begin
    if (one_shot_rst) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      owner              <= '0;
      gap_ctr            <= '0;
      bus.tx_start       <= 1'b0;
      bus.tx_data        <= '0;
      bus.tx_parity_type <= '0;
      bus.grant          <= '0;
      bus.done           <= '0;
      bus.arb_busy       <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      wdog_ctr           <= '0;
      bus.err            <= '0;
`endif
    end else begin
      bus.tx_start <= 1'b0;
      bus.done     <= '0;
`ifdef UART_ARB_WDOG_EN
      bus.err      <= '0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.tx_data        <= bus.req_data[{pick_idx, 3'b000} +: 8];
            bus.tx_parity_type <= norm_parity(bus.cfg_parity_type);
            bus.grant          <= pick_win;
            owner              <= pick_idx;
            // Start pulse is registered here so it is high exactly while in GRANT.
            bus.tx_start       <= 1'b1;
            bus.arb_busy       <= 1'b1;
            state              <= GRANT;
          end
        end
        GRANT: begin
`ifdef UART_ARB_WDOG_EN
          wdog_ctr <= '0;
`endif
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
`ifdef UART_ARB_WDOG_EN
          end else if (wdog_ctr == CTR_W'(WDOG_CYCLES - 1)) begin
            bus.err   <= bus.grant;
            bus.grant <= '0;
            rr_ptr    <= owner + 2'd1;
            gap_ctr   <= '0;
            state     <= GAP;
          end else begin
            wdog_ctr <= wdog_ctr + 1'b1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            bus.done  <= bus.grant;
            bus.grant <= '0;
            rr_ptr    <= owner + 2'd1;
            gap_ctr   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_ctr == CTR_W'(GAP_CYCLES - 1)) begin
            bus.arb_busy <= 1'b0;
            state        <= IDLE;
          end else begin
            gap_ctr <= gap_ctr + 1'b1;
          end
        end
        default: begin
          bus.arb_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: timestamp-based reference model plus directed scenarios.
module tb_uart_tx_arbiter;

  localparam int GAP  = 434;
  localparam int WDOG = 868;
`ifdef UART_ARB_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic one_shot_rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
    .clk          (clk),
    .one_shot_rst (one_shot_rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: frames described by the edge numbers at which they happen.
  bit         m_active = 0, m_seen = 0;
  int         m_owner = 0, m_ptr = 0, m_ready = 0, m_grant_edge = 0;
  logic [7:0] m_data = '0;
  logic [1:0] m_par = '0;
  logic       e_start = 0, e_abusy = 0;
  logic [3:0] e_grant = '0, e_done = '0, e_err = '0;

  always @(posedge clk or posedge one_shot_rst) begin
    if (one_shot_rst) begin
      m_active = 0; m_seen = 0; m_ptr = 0; m_ready = 0; m_data = '0; m_par = '0;
      e_start = 0; e_abusy = 0; e_grant = '0; e_done = '0; e_err = '0;
    end else begin
      cyc = cyc + 1;
      e_start = 0; e_done = '0; e_err = '0;
      if (m_active) begin
        if (cyc >= m_grant_edge + 2) begin
          if (!m_seen) begin
            if (bus.tx_busy) m_seen = 1;
            else if (WDOG_EN && cyc == m_grant_edge + 1 + WDOG) begin
              e_err = 4'(1 << m_owner);
              m_active = 0; m_ptr = (m_owner + 1) % 4; m_ready = cyc + GAP + 1;
            end
          end else if (!bus.tx_busy) begin
            e_done = 4'(1 << m_owner);
            m_active = 0; m_ptr = (m_owner + 1) % 4; m_ready = cyc + GAP + 1;
          end
        end
      end else if (cyc >= m_ready && bus.req != 4'b0) begin
        for (int k = 3; k >= 0; k--)
          if (bus.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        m_active = 1; m_seen = 0; m_grant_edge = cyc; e_start = 1;
        m_data = bus.req_data[8*m_owner +: 8];
        m_par  = (bus.cfg_parity_type == 2'd3) ? 2'd0 : bus.cfg_parity_type;
      end
      e_grant = m_active ? 4'(1 << m_owner) : 4'b0;
      e_abusy = m_active || (cyc < m_ready - 1);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx_start", bus.tx_start, e_start);
    chk("grant", bus.grant, e_grant);
    chk("done", bus.done, e_done);
    chk("err", bus.err, e_err);
    chk("arb_busy", bus.arb_busy, e_abusy);
    chk("tx_data", bus.tx_data, m_data);
    chk("tx_parity_type", bus.tx_parity_type, m_par);
  end

  // Transmitter stub: busy for busy_len cycles after each start.
  int busy_len = 20;
  int busy_left = 0;
  bit stub_en = 1;
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (one_shot_rst) begin
        busy_left = 0; bus.tx_busy = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_start && stub_en) begin
        bus.tx_busy = 1'b1; busy_left = busy_len;
      end
    end
  end

  task automatic wait_start(output logic [3:0] g, output int at);
    g = '0; at = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin g = bus.grant; at = cyc; return; end
    end
    n_chk++; n_fail++;
    $display("FAIL start_timeout: got no tx_start expected one within 5000 cycles");
  endtask

  task automatic wait_end(output logic [3:0] d, output int at);
    d = '0; at = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ((bus.done | bus.err) != 4'b0) begin d = bus.done | bus.err; at = cyc; return; end
    end
    n_chk++; n_fail++;
    $display("FAIL end_timeout: got no done/err expected one within 5000 cycles");
  endtask

  task automatic do_reset();
    @(negedge clk); #1 one_shot_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 one_shot_rst = 1'b0;
  endtask

  logic [3:0] g, d;
  int s, s2, dc;
  logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    bus.req = '0; bus.req_data = '0; bus.cfg_parity_type = '0;
    #1;
    chk("reset_grant", bus.grant, 4'b0);
    chk("reset_arb_busy", bus.arb_busy, 1'b0);
    chk("reset_tx_start", bus.tx_start, 1'b0);
    repeat (2) @(negedge clk);
    #1 one_shot_rst = 1'b0;

    // Single requester, even parity, 100-cycle frame, re-requests after the gap.
    bus.cfg_parity_type = 2'd2; bus.req_data = 32'h00A5_0000; busy_len = 100;
    bus.req = 4'b0100;
    wait_start(g, s);
    chk("single_grant", g, 4'b0100);
    chk("single_data", bus.tx_data, 8'hA5);
    chk("single_parity", bus.tx_parity_type, 2'd2);
    wait_end(d, dc);
    chk("single_done", d, 4'b0100);
    chk("single_done_latency", dc - s, 101);
    wait_start(g, s2);
    chk("single_regrant_gap", s2 - dc, GAP + 1);
    wait_end(d, dc);
    #1 bus.req = '0;

    // Four concurrent requesters from reset.
    do_reset();
    bus.req_data = 32'h4433_2211; bus.cfg_parity_type = 2'd1; busy_len = 20;
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_start(g, s);
      chk("rr_grant", g, rr_order[k]);
      if (k > 0) chk("rr_gap", s - dc, GAP + 1);
      wait_end(d, dc);
      chk("rr_done", d, rr_order[k]);
    end
    #1 bus.req = '0;

    // Owner withdraws during its frame; frame completes, next requester served.
    do_reset();
    busy_len = 30; bus.req = 4'b0011;
    wait_start(g, s);
    chk("drop_grant", g, 4'b0001);
    repeat (10) @(negedge clk);
    #1 bus.req = 4'b0010;
    wait_end(d, dc);
    chk("drop_done", d, 4'b0001);
    wait_start(g, s);
    chk("drop_next", g, 4'b0010);
    wait_end(d, dc);
    #1 bus.req = '0;

    // Reset during WAIT_DONE; pointer must return to requester 0.
    bus.req = 4'b0100;
    wait_start(g, s);
    chk("rst_pre_grant", g, 4'b0100);
    repeat (10) @(negedge clk);
    #1 one_shot_rst = 1'b1; bus.req = '0;
    #1;
    chk("rst_grant", bus.grant, 4'b0);
    chk("rst_arb_busy", bus.arb_busy, 1'b0);
    repeat (2) @(negedge clk);
    #1 one_shot_rst = 1'b0; bus.req = 4'b1001;
    wait_start(g, s);
    chk("rst_ptr_winner", g, 4'b0001);
    wait_end(d, dc);
    #1 bus.req = '0;

    // Reserved parity code.
    bus.cfg_parity_type = 2'd3; bus.req_data = 32'h0000_005A; bus.req = 4'b0001;
    wait_start(g, s);
    chk("par3_parity", bus.tx_parity_type, 2'd0);
    chk("par3_data", bus.tx_data, 8'h5A);
    wait_end(d, dc);
    #1 bus.req = '0;

`ifdef UART_ARB_WDOG_EN
    // Transmitter never responds; watchdog aborts and the next requester is served.
    do_reset();
    stub_en = 0; bus.req = 4'b0011;
    wait_start(g, s);
    chk("wdog_grant", g, 4'b0001);
    wait_end(d, dc);
    chk("wdog_err", bus.err, 4'b0001);
    chk("wdog_latency", dc - s, WDOG + 1);
    #1 stub_en = 1; bus.req = 4'b0010;
    wait_start(g, s);
    chk("wdog_next", g, 4'b0010);
    wait_end(d, dc);
    chk("wdog_next_done", bus.done, 4'b0010);
    #1 bus.req = '0;
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
